spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI mode-0 responder: the other end of the link driven by our SPI master (cs/sclk/mosi in, miso out).
//  Oversamples the asynchronous SPI pins on the system clock, shifts DATA_WIDTH-bit words MSB-first in both directions.
//  Presents each received word with a one-cycle valid strobe and latches the next word to transmit at word boundaries.
//  Used as the bench partner for the master and as the device-side block in loopback builds.
// PARAMETERS
//  DATA_WIDTH  8  bits per SPI word (>=2)
//  SYNC_STAGES 2  synchronizer flops on cs/sclk/mosi (>=2)
// PORTS
//  clk       input   1           system clock, must be >= 4x sclk frequency
//  reset     input   1           asynchronous, active-low reset
//  cs        input   1           chip select from master, active-low, async to clk
//  sclk      input   1           SPI clock from master, idle low, async to clk
//  mosi      input   1           serial data from master
//  tx_data   input   DATA_WIDTH  next word to transmit, sampled when tx_load pulses
//  miso      output  1           serial data to master
//  rx_data   output  DATA_WIDTH  last complete received word, held until next word completes
//  rx_valid  output  1           one-cycle pulse: rx_data updated
//  tx_load   output  1           one-cycle pulse: tx_data captured into shift register
//  busy      output  1           high while a frame (cs low, synchronized) is active
// BEHAVIOUR
//  Reset (reset=0, async): miso=0, rx_data=0, rx_valid=0, tx_load=0, busy=0, bit counter=0, FSM=IDLE, sync flops=1 for cs, 0 for sclk/mosi.
//  Sync: cs/sclk/mosi pass SYNC_STAGES flops; one extra flop per signal gives edge detect (rise/fall = 1-cycle pulses).
//  FSM IDLE: busy=0, miso=0. On synchronized cs fall -> LOAD.
//  FSM LOAD (1 cycle): tx_shift<=tx_data, tx_load=1, bit_cnt<=0, busy=1 -> SHIFT.
//  FSM SHIFT: miso = tx_shift[MSB] at all times.
//   - sclk rise: rx_shift<={rx_shift[DW-2:0], mosi_sync}; bit_cnt++.
//   - sclk fall: tx_shift<<=1 (LSB fill 0), except when bit_cnt==0 (word boundary; MSB already presented).
//   - sclk rise with bit_cnt==DW-1: next cycle rx_data<={rx_shift[DW-2:0],mosi_sync}, rx_valid=1, bit_cnt<=0,
//     and tx_shift<=tx_data with tx_load=1 in that same cycle (back-to-back words in one frame).
//   - synchronized cs rise -> IDLE from any state; partial word (bit_cnt!=0) discarded, no rx_valid, rx_data unchanged.
//  Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after 8th (DW-th) sclk rising pin edge.
//  Simultaneous cs rise and final sclk rise in same cycle: word completes (rx_valid=1), then IDLE.
//  sclk edges while cs high: ignored, no state change.
//  reset asserted mid-frame: immediate return to reset values; next cs fall starts fresh frame.
//  No tristate: miso driven 0 outside a frame.
// TESTING
//  1 Reset: hold reset=0 with random pins -> all outputs 0; release, sclk toggles with cs=1 -> no rx_valid/tx_load.
//  2 Single word: tx_data=8'hA5, master sends 8'h3C -> tx_load at frame start, miso bits 1,0,1,0,0,1,0,1, rx_data=8'h3C with one rx_valid pulse.
//  3 Back-to-back: one cs-low frame, master sends 8'h01,8'hFE; tx_data changes 8'h55->8'hAA on tx_load -> rx_valid x2 (8'h01 then 8'hFE), miso 8'h55 then 8'hAA.
//  4 Abort: cs rises after 5 sclk rises -> no rx_valid, rx_data keeps previous value, busy=0, miso=0; next full frame 8'h81 received correctly.
//  5 Loopback with master (clk divider 4x): data_in 8'hC3 on master, tx_data 8'h5A on slave -> master data_out=8'h5A, slave rx_data=8'hC3.
//  6 Reset mid-frame after 3 bits -> outputs return to reset values at once; following frame 8'hF0 received intact.

Source files
------------

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI mode-0 slave: oversamples cs/sclk/mosi on clk_i and shifts MSB-first DATA_WIDTH-bit words both ways.
// Each received word pulses rx_valid_o; the next transmit word is captured at frame start and word boundaries.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  cs_ni,
    input  logic                  sclk_i,
    input  logic                  mosi_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  miso_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_load_o,
    output logic                  busy_o
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    logic [SYNC_STAGES:0]   cs_sync_q;
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   done_q, done_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_load_q, tx_load_d;
    logic                   miso_q, miso_d;
    logic                   busy_q, busy_d;

    logic cs_s, cs_fall_s, cs_rise_s;
    logic sclk_rise_s, sclk_fall_s;
    logic mosi_s;

    // Pin synchronizers; the top bit of the cs/sclk chains holds the previous synchronized value.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], cs_ni};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign cs_fall_s   = ~cs_s & cs_sync_q[SYNC_STAGES];
    assign cs_rise_s   = cs_s & ~cs_sync_q[SYNC_STAGES];
    assign sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    assign sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    // Frame FSM, shift datapath and registered output next-state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = ZERO_CNT;
                if (cs_fall_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_shift_d = tx_data_i;
                tx_load_d  = 1'b1;
                bit_cnt_d  = ZERO_CNT;
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_CNT) begin
                        bit_cnt_d = ZERO_CNT;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + ONE_CNT;
                    end
                end else if (sclk_fall_s && (bit_cnt_q != ZERO_CNT)) begin
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    tx_shift_d = tx_shift_q;
                end
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completed word publishes even if cs rose with the last edge; reload only if the frame continues.
        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if ((state_q == ST_SHIFT) && (state_d == ST_SHIFT)) begin
                tx_shift_d = tx_data_i;
                tx_load_d  = 1'b1;
            end else begin
                tx_load_d  = 1'b0;
            end
        end else begin
            rx_valid_d = 1'b0;
        end

        if (state_d == ST_SHIFT) begin
            miso_d = tx_shift_d[DATA_WIDTH-1];
        end else begin
            miso_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
        end
    end

    assign miso_o     = miso_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_load_o  = tx_load_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Bench for spi_slave: a behavioural mode-0 master drives frames; received words are checked via a scoreboard queue.
module tb_spi_slave;
    localparam int DW       = 8;
    localparam int HALF_CYC = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cs_n;
    logic          sclk;
    logic          mosi;
    logic [DW-1:0] tx_data;
    logic          miso;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_load;
    logic          busy;

    always #5 clk = ~clk;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .cs_ni      (cs_n),
        .sclk_i     (sclk),
        .mosi_i     (mosi),
        .tx_data_i  (tx_data),
        .miso_o     (miso),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .tx_load_o  (tx_load),
        .busy_o     (busy)
    );

    typedef struct packed {
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[64];
    int         rx_cnt = 0;
    int         tx_load_cnt = 0;
    int         rd_idx = 0;

    // Output monitor: logs every rx_valid pulse and counts tx_load pulses.
    always @(negedge clk) begin
        if (rx_valid && rx_cnt < 64) begin
            rx_log[rx_cnt] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_load) tx_load_cnt = tx_load_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half_bit();
        repeat (HALF_CYC) @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        half_bit();
    endtask

    task automatic end_frame();
        half_bit();
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
    endtask

    // One full word: scoreboard entry pushed as the word is driven, miso sampled at each rising sclk.
    task automatic send_word(input logic [7:0] w, input logic [7:0] exp_miso,
                             input logic [7:0] next_tx, input string name);
        logic [7:0] got;
        got = 8'h00;
        exp_q.push_back(w);
        for (int i = 7; i >= 0; i--) begin
            mosi = w[i];
            half_bit();
            got[i] = miso;
            sclk = 1'b1;
            if (i == 7) tx_data = next_tx;
            half_bit();
            sclk = 1'b0;
        end
        chk({name, " miso"}, 32'(got), 32'(exp_miso));
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = w[i];
            half_bit();
            sclk = 1'b1;
            half_bit();
            sclk = 1'b0;
        end
    endtask

    task automatic check_rx(input string name);
        int         t;
        logic [7:0] exp;
        t = 0;
        while (rx_cnt <= rd_idx && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rx_cnt > rd_idx) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            chk({name, " rx_data"}, 32'(rx_log[rd_idx]), 32'(exp));
            rd_idx++;
        end else begin
            checks++;
            errors++;
            $display("FAIL %s rx_valid: got none within 200 cycles, expected a word", name);
        end
    endtask

    vec_t vecs[4];
    int   ld0;
    int   rx0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mosi_w: 8'h3C, tx_w: 8'hA5, exp_rx: 8'h3C, exp_miso: 8'hA5};
        vecs[1] = '{mosi_w: 8'hC3, tx_w: 8'h5A, exp_rx: 8'hC3, exp_miso: 8'h5A};
        vecs[2] = '{mosi_w: 8'hFF, tx_w: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{mosi_w: 8'h00, tx_w: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};

        // Reset held with random pins: every output must read zero.
        reset_n = 1'b0;
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            cs_n    = 1'($urandom);
            sclk    = 1'($urandom);
            mosi    = 1'($urandom);
            tx_data = 8'($urandom);
            @(posedge clk); #1;
            chk("reset outputs", 32'({miso, rx_data, rx_valid, tx_load, busy}), 32'h0);
        end
        cs_n = 1'b1; sclk = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            repeat (4) @(posedge clk);
        end
        sclk = 1'b0;
        repeat (4) @(posedge clk); #2;
        chk("cs high rx_valid count", 32'(rx_cnt), 32'd0);
        chk("cs high tx_load count", 32'(tx_load_cnt), 32'd0);
        chk("cs high busy", 32'(busy), 32'd0);

        // Single-word frames from the table (includes the 8'hC3 / 8'h5A loopback pair).
        for (int i = 0; i < 4; i++) begin
            tx_data = vecs[i].tx_w;
            ld0 = tx_load_cnt;
            start_frame();
            chk("busy in frame", 32'(busy), 32'd1);
            send_word(vecs[i].mosi_w, vecs[i].exp_miso, 8'h00, "vec");
            check_rx("vec");
            end_frame();
            chk("vec tx_load pulses", 32'(tx_load_cnt - ld0), 32'd2);
            chk("vec rx_data held", 32'(rx_data), 32'(vecs[i].exp_rx));
            chk("vec idle busy/miso", 32'({busy, miso}), 32'd0);
        end

        // Back-to-back words in one frame, transmit word swapped after the first capture.
        tx_data = 8'h55;
        ld0 = tx_load_cnt;
        start_frame();
        send_word(8'h01, 8'h55, 8'hAA, "b2b w0");
        send_word(8'hFE, 8'hAA, 8'h00, "b2b w1");
        check_rx("b2b w0");
        check_rx("b2b w1");
        end_frame();
        chk("b2b tx_load pulses", 32'(tx_load_cnt - ld0), 32'd3);
        chk("b2b rx_data held", 32'(rx_data), 32'hFE);

        // Abort after five bits: partial word dropped, previous rx_data kept.
        tx_data = 8'h3C;
        ld0 = tx_load_cnt;
        rx0 = rx_cnt;
        start_frame();
        send_bits(8'hB7, 5);
        end_frame();
        chk("abort no rx_valid", 32'(rx_cnt - rx0), 32'd0);
        chk("abort rx_data kept", 32'(rx_data), 32'hFE);
        chk("abort idle busy/miso", 32'({busy, miso}), 32'd0);
        chk("abort tx_load pulses", 32'(tx_load_cnt - ld0), 32'd1);
        tx_data = 8'h66;
        start_frame();
        send_word(8'h81, 8'h66, 8'h00, "after abort");
        check_rx("after abort");
        end_frame();

        // Reset asserted mid-frame after three bits, then a clean frame.
        tx_data = 8'h99;
        start_frame();
        send_bits(8'hE0, 3);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midframe reset outputs", 32'({miso, rx_data, rx_valid, tx_load, busy}), 32'h0);
        cs_n = 1'b1;
        repeat (3) @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (4) @(posedge clk); #2;
        tx_data = 8'h0F;
        start_frame();
        send_word(8'hF0, 8'h0F, 8'h00, "after reset");
        check_rx("after reset");
        end_frame();
        chk("after reset rx_data held", 32'(rx_data), 32'hF0);

        chk("no spurious rx_valid", 32'(rx_cnt), 32'(rd_idx));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
